// File: rtl/miner_nonce_sequencer.sv
// miner_nonce_sequencer: walks a nonce range through the miner core. For each
// nonce it launches the core, waits for its result, and compares the result
// against the job target. Winners go out over a valid/ready handshake.
//
// state       | meaning
// S_IDLE      | no job; job_ready high
// S_LAUNCH    | hash_enable pulse for the current nonce; watchdog reloads
// S_WAIT_CORE | waiting for core_finished or watchdog expiry
// S_CHECK     | compare captured hash against target
// S_REPORT    | winner offered on found_*; search stalled until accepted
// S_DONE      | one-cycle done pulse, range exhausted
module miner_nonce_sequencer #(
  parameter int NONCE_W = 32,
  parameter int HASH_W  = 256,
  parameter int TIMEOUT = 512
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [NONCE_W-1:0] start_nonce,
  input  logic [NONCE_W-1:0] end_nonce,
  input  logic [HASH_W-1:0]  target,
  input  logic               abort,
  output logic               hash_enable,
  output logic [NONCE_W-1:0] nonce,
  input  logic               core_finished,
  input  logic [HASH_W-1:0]  hash_result,
  output logic               found_valid,
  output logic [NONCE_W-1:0] found_nonce,
  input  logic               found_ready,
  output logic               done,
  output logic               busy,
  output logic               timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_CORE,
    S_CHECK,
    S_REPORT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [NONCE_W-1:0] nonce_q, end_q, found_q;
  logic [HASH_W-1:0]  target_q, hash_q;
  logic [WD_W-1:0]    wd_cnt;
  logic               timeout_q;

  logic load_job, cap_hash, set_found, inc_nonce, set_timeout;
  logic hit, last, wd_tc;

  // Compare works only on registered operands, keeping hash_result off any output path.
  assign hit   = (hash_q <= target_q);
  assign last  = (nonce_q == end_q);
  // Down-counter loaded in LAUNCH reaches zero after TIMEOUT cycles of WAIT_CORE.
  assign wd_tc = (wd_cnt == '0);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath strobes; abort overrides everything.
  always_comb begin
    state_nxt   = state;
    load_job    = 1'b0;
    cap_hash    = 1'b0;
    set_found   = 1'b0;
    inc_nonce   = 1'b0;
    set_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (job_valid) begin
          load_job  = 1'b1;
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: state_nxt = S_WAIT_CORE;
      S_WAIT_CORE: begin
        if (core_finished) begin
          cap_hash  = 1'b1;
          state_nxt = S_CHECK;
        end else if (wd_tc) begin
          set_timeout = 1'b1;
          state_nxt   = S_LAUNCH;
        end
      end
      S_CHECK: begin
        if (hit) begin
          set_found = 1'b1;
          state_nxt = S_REPORT;
        end else if (last) begin
          state_nxt = S_DONE;
        end else begin
          inc_nonce = 1'b1;
          state_nxt = S_LAUNCH;
        end
      end
      S_REPORT: begin
        if (found_ready) begin
          if (last) begin
            state_nxt = S_DONE;
          end else begin
            inc_nonce = 1'b1;
            state_nxt = S_LAUNCH;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt   = S_IDLE;
      load_job    = 1'b0;
      cap_hash    = 1'b0;
      set_found   = 1'b0;
      inc_nonce   = 1'b0;
      set_timeout = 1'b0;
    end
  end

  // Job registers, nonce walker, captured hash, winner and sticky timeout flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      nonce_q   <= '0;
      end_q     <= '0;
      target_q  <= '0;
      hash_q    <= '0;
      found_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (load_job) begin
        nonce_q   <= start_nonce;
        end_q     <= end_nonce;
        target_q  <= target;
        timeout_q <= 1'b0;
      end
      if (inc_nonce)   nonce_q   <= nonce_q + NONCE_W'(1);
      if (cap_hash)    hash_q    <= hash_result;
      if (set_found)   found_q   <= nonce_q;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  // Watchdog: reload on every launch, count down while waiting on the core.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_cnt <= '0;
    end else if (state == S_LAUNCH) begin
      wd_cnt <= WD_W'(TIMEOUT - 1);
    end else if (state == S_WAIT_CORE && !wd_tc) begin
      wd_cnt <= wd_cnt - WD_W'(1);
    end
  end

  assign job_ready   = (state == S_IDLE);
  assign hash_enable = (state == S_LAUNCH);
  assign found_valid = (state == S_REPORT);
  assign done        = (state == S_DONE);
  assign busy        = (state != S_IDLE);
  assign nonce       = nonce_q;
  assign found_nonce = found_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_miner_nonce_sequencer.sv
// Bench for miner_nonce_sequencer: directed scenarios plus randomized jobs,
// checked against a range/target model and a behavioural miner core.
module tb_miner_nonce_sequencer;

  localparam int NW = 32;
  localparam int HW = 256;
  localparam int TO = 512;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [NW-1:0] start_nonce = '0;
  logic [NW-1:0] end_nonce = '0;
  logic [HW-1:0] target = '0;
  logic          abort = 1'b0;
  logic          hash_enable;
  logic [NW-1:0] nonce;
  logic          core_finished = 1'b0;
  logic [HW-1:0] hash_result = '0;
  logic          found_valid;
  logic [NW-1:0] found_nonce;
  logic          found_ready = 1'b1;
  logic          done;
  logic          busy;
  logic          timeout_err;

  miner_nonce_sequencer #(.NONCE_W(NW), .HASH_W(HW), .TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst), .job_valid(job_valid), .job_ready(job_ready),
    .start_nonce(start_nonce), .end_nonce(end_nonce), .target(target),
    .abort(abort), .hash_enable(hash_enable), .nonce(nonce),
    .core_finished(core_finished), .hash_result(hash_result),
    .found_valid(found_valid), .found_nonce(found_nonce),
    .found_ready(found_ready), .done(done), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // Job/model state
  int            mode = 0;
  logic [31:0]   seed = 32'h1234_5678;
  logic [HW-1:0] tgt_cur = '0;
  int            lat = 5;
  bit            drop_armed = 1'b0;
  logic [NW-1:0] drop_n = '0;

  // Observations from the core model / monitors
  logic [NW-1:0] launched[$];
  int            launch_cyc[$];
  int            fin_cyc[$];
  logic [NW-1:0] found_q[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            acc_cyc = 0;

  // Expected from the model
  logic [NW-1:0] exp_launch[$];
  logic [NW-1:0] exp_win[$];

  // Free-running cycle index
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [HW-1:0] hash_fn(input logic [NW-1:0] n);
    logic [31:0] w;
    if (mode == 1) return (n == 32'd5) ? tgt_cur : {HW{1'b1}};
    w = (n ^ seed) * 32'h9E37_79B9;
    return {w, {7{w ^ seed}}};
  endfunction

  // Behavioural miner core plus handshake/done monitors, all on the falling edge
  int            core_cnt = -1;
  logic [NW-1:0] core_pend = '0;
  always @(negedge clk) begin
    core_finished = 1'b0;
    if (core_cnt > 0) core_cnt--;
    if (core_cnt == 0) begin
      core_finished = 1'b1;
      hash_result   = hash_fn(core_pend);
      fin_cyc.push_back(cyc);
      core_cnt = -1;
    end
    if (hash_enable) begin
      launched.push_back(nonce);
      launch_cyc.push_back(cyc);
      core_pend = nonce;
      if (drop_armed && nonce == drop_n) drop_armed = 1'b0;
      else core_cnt = lat;
    end
    if (found_valid && found_ready) found_q.push_back(found_nonce);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: every nonce from s to e inclusive (mod 2^32), each tested once
  // (twice if the core drops it), winners are those whose hash <= target.
  task automatic build_expected(input logic [NW-1:0] s, input logic [NW-1:0] e, input bit use_drop);
    logic [NW-1:0] n;
    exp_launch.delete();
    exp_win.delete();
    n = s;
    for (int k = 0; k < 64; k++) begin
      exp_launch.push_back(n);
      if (use_drop && n == drop_n) exp_launch.push_back(n);
      if (hash_fn(n) <= tgt_cur) exp_win.push_back(n);
      if (n == e) break;
      n = n + 32'd1;
    end
  endtask

  task automatic start_job(input logic [NW-1:0] s, input logic [NW-1:0] e);
    for (int i = 0; i < 50 && !job_ready; i++) tick();
    chk("job_ready_before_accept", job_ready, 1'b1);
    launched.delete();
    launch_cyc.delete();
    fin_cyc.delete();
    found_q.delete();
    done_cnt    = 0;
    start_nonce = s;
    end_nonce   = e;
    target      = tgt_cur;
    job_valid   = 1'b1;
    acc_cyc     = cyc;
    tick();
    job_valid   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    chk("done_seen", done_cnt > 0, 1'b1);
  endtask

  task automatic check_job(input string name);
    chk({name, "_launch_count"}, launched.size(), exp_launch.size());
    for (int i = 0; i < exp_launch.size(); i++)
      chk($sformatf("%s_nonce%0d", name, i), (i < launched.size()) ? launched[i] : 32'hx, exp_launch[i]);
    chk({name, "_found_count"}, found_q.size(), exp_win.size());
    for (int i = 0; i < exp_win.size(); i++)
      chk($sformatf("%s_found%0d", name, i), (i < found_q.size()) ? found_q[i] : 32'hx, exp_win[i]);
    chk({name, "_done_count"}, done_cnt, 1);
    chk({name, "_first_launch_lat"}, (launch_cyc.size() > 0) ? launch_cyc[0] - acc_cyc : -1, 1);
    chk({name, "_ready_after_done"}, job_ready, 1'b1);
    chk({name, "_idle_after_done"}, busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_job_ready"}, job_ready, 1'b1);
    chk({name, "_hash_enable"}, hash_enable, 1'b0);
    chk({name, "_found_valid"}, found_valid, 1'b0);
    chk({name, "_done"}, done, 1'b0);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_timeout_err"}, timeout_err, 1'b0);
    chk({name, "_nonce"}, nonce, 32'd0);
    chk({name, "_found_nonce"}, found_nonce, 32'd0);
  endtask

  initial begin
    logic [NW-1:0] s, e;
    int nl;

    // Reset values
    #3;
    check_reset_outputs("rst");
    tick();
    n_rst = 1'b1;
    tick();

    // Range 0x10..0x12, target all-ones: every nonce wins
    mode = 0; lat = 5; found_ready = 1'b1;
    tgt_cur = {HW{1'b1}};
    build_expected(32'h10, 32'h12, 1'b0);
    start_job(32'h10, 32'h12);
    wait_done(300);
    check_job("allwin");

    // Wrapping range, target 0: no winners; per-nonce spacing lat+2, done at f+2
    lat = $urandom_range(1, 8);
    tgt_cur = '0;
    build_expected(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    start_job(32'hFFFF_FFFE, 32'h0000_0001);
    wait_done(300);
    check_job("wrap");
    for (int i = 1; i < launch_cyc.size(); i++)
      chk($sformatf("wrap_gap%0d", i), launch_cyc[i] - launch_cyc[i-1], lat + 2);
    chk("wrap_done_cyc", (fin_cyc.size() > 0) ? done_cyc - fin_cyc[fin_cyc.size()-1] : -1, 2);

    // Single winner 5 in 0..7 with 10 cycles of back-pressure
    mode = 1; lat = $urandom_range(1, 4); found_ready = 1'b0;
    for (int w = 0; w < 8; w++) tgt_cur[w*32 +: 32] = $urandom;
    tgt_cur[HW-1] = 1'b0;
    build_expected(32'd0, 32'd7, 1'b0);
    start_job(32'd0, 32'd7);
    for (int i = 0; i < 200 && !found_valid; i++) tick();
    chk("bp_found_valid_rise", found_valid, 1'b1);
    chk("bp_found_valid_lat", (fin_cyc.size() > 0) ? cyc - fin_cyc[fin_cyc.size()-1] : -1, 2);
    nl = launched.size();
    chk("bp_launches_before_hit", nl, 6);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp_hold_valid%0d", i), found_valid, 1'b1);
      chk($sformatf("bp_hold_nonce%0d", i), found_nonce, 32'd5);
      chk($sformatf("bp_stall%0d", i), launched.size(), nl);
    end
    found_ready = 1'b1;
    wait_done(300);
    check_job("bp");

    // Core drops nonce 3 once: watchdog relaunch after TIMEOUT cycles of waiting
    mode = 0; lat = $urandom_range(1, 6);
    for (int w = 0; w < 8; w++) tgt_cur[w*32 +: 32] = $urandom;
    drop_n = 32'd3; drop_armed = 1'b1;
    build_expected(32'd0, 32'd5, 1'b1);
    start_job(32'd0, 32'd5);
    wait_done(2000);
    check_job("wdog");
    chk("wdog_relaunch_gap", (launch_cyc.size() > 4) ? launch_cyc[4] - launch_cyc[3] : -1, TO + 1);
    chk("wdog_timeout_err", timeout_err, 1'b1);
    drop_armed = 1'b0;
    s = $urandom; e = s + 32'd2;
    build_expected(s, e, 1'b0);
    start_job(s, e);
    chk("wdog_err_cleared", timeout_err, 1'b0);
    wait_done(300);
    check_job("after_wdog");

    // Abort in WAIT_CORE, then the core's late finish must be ignored
    lat = 6;
    start_job(32'h20, 32'h23);
    for (int i = 0; i < 20 && launched.size() == 0; i++) tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_job_ready", job_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_hash_enable", hash_enable, 1'b0);
    for (int i = 0; i < 12; i++) tick();
    chk("abort_late_fin_seen", fin_cyc.size(), 1);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_relaunch", launched.size(), 1);
    chk("abort_still_idle", busy, 1'b0);
    chk("abort_nonce_hold", nonce, 32'h20);

    // Asynchronous reset while a winner is being offered
    mode = 1; lat = 3; found_ready = 1'b0;
    start_job(32'd4, 32'd6);
    for (int i = 0; i < 100 && !found_valid; i++) tick();
    chk("rstrep_in_report", found_valid, 1'b1);
    n_rst = 1'b0;
    #1;
    check_reset_outputs("rstrep");
    tick();
    tick();
    n_rst = 1'b1;
    found_ready = 1'b1;
    tick();

    // Randomized jobs
    mode = 0;
    for (int j = 0; j < 8; j++) begin
      s = $urandom;
      if ($urandom_range(0, 2) == 0) s = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      e = s + 32'($urandom_range(0, 5));
      for (int w = 0; w < 8; w++) tgt_cur[w*32 +: 32] = $urandom;
      seed = $urandom;
      lat  = $urandom_range(1, 8);
      build_expected(s, e, 1'b0);
      start_job(s, e);
      wait_done(400);
      check_job($sformatf("rnd%0d", j));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
